// File: rtl/cpu_sequencer_pkg.sv
// cpu_sequencer_pkg: opcode constants, instruction field ranges and
// sequencer state encodings shared by the sequencer and the decoder.
// Optional feature macro: SEQ_SINGLE_STEP_EN adds the SEQ_IDLE state.
`ifndef CPU_SEQUENCER_PKG_SV
`define CPU_SEQUENCER_PKG_SV

`define INST_OP  15:12
`define INST_Rd  11:9
`define INST_Rs  8:6
`define INST_Rt  5:3
`define INST_Imm 7:0

package cpu_sequencer_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_XOR   = 4'h5;
  localparam logic [3:0] OP_LOADI = 4'h6;
  localparam logic [3:0] OP_JMP   = 4'h7;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [2:0] {
    SEQ_FETCH  = 3'd0,
    SEQ_DECODE = 3'd1,
    SEQ_EXEC   = 3'd2,
    SEQ_WB     = 3'd3,
    SEQ_HALT   = 3'd4
`ifdef SEQ_SINGLE_STEP_EN
    , SEQ_IDLE = 3'd5
`endif
  } seq_state_e;

  // Register-to-register ALU operations (need both ALU and write-back phases)
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_XOR);
  endfunction

  // Opcodes 8..E have no defined meaning
  function automatic logic is_defined_op(input logic [3:0] op);
    return (op <= OP_JMP) || (op == OP_HALT);
  endfunction

endpackage

`endif

// File: rtl/cpu_sequencer_seq_pc.sv
// cpu_sequencer_seq_pc: program counter register.
// Priority: reset load > jump load > increment (wraps modulo 2^PC_W).
module cpu_sequencer_seq_pc #(
  parameter int PC_W     = 8,
  parameter int RESET_PC = 0
) (
  input  logic            clk,
  input  logic            res,
  input  logic            jmp,
  input  logic [PC_W-1:0] jmp_addr,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_q;

  // PC update with reset > jump > increment priority
  always_ff @(posedge clk) begin
    if (res) begin
      pc_q <= PC_W'(RESET_PC);
    end else if (jmp) begin
      pc_q <= jmp_addr;
    end else if (inc) begin
      pc_q <= pc_q + PC_W'(1);
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute/write-back control FSM
// for the 16-bit CPU. Owns the instruction register, PC, halt and the
// retired-instruction counter.
// Optional feature macro: SEQ_SINGLE_STEP_EN (STEP input, IDLE state).
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int PC_W     = 8,
  parameter int RESET_PC = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             res,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic             STEP,
`endif
  output logic             IMEM_REQ,
  output logic [PC_W-1:0]  IMEM_ADDR,
  input  logic             IMEM_ACK,
  input  logic [15:0]      IMEM_DATA,
  output logic [15:0]      INST,
  output logic             DEC_EN,
  output logic             ALU_EN,
  output logic             WB_EN,
  output logic [PC_W-1:0]  PC,
  output logic             HALTED,
  output logic             ILLEGAL,
  output logic [CNT_W-1:0] RETIRED
);

  // Where the FSM goes after reset and after each retirement
`ifdef SEQ_SINGLE_STEP_EN
  localparam seq_state_e RETURN_STATE = SEQ_IDLE;
`else
  localparam seq_state_e RETURN_STATE = SEQ_FETCH;
`endif

  seq_state_e       state, state_nxt;
  logic [15:0]      inst_q;
  logic [CNT_W-1:0] retired_q;
  logic [3:0]       op;
  logic             ir_load, pc_inc, pc_jmp, retire;
  logic [PC_W-1:0]  jmp_target;
  logic [PC_W-1:0]  pc_w;

  assign op = inst_q[`INST_OP];

  // Jump target: 8-bit immediate zero-extended or truncated to PC_W
  generate
    if (PC_W > 8) begin : g_imm_ext
      assign jmp_target = {{(PC_W-8){1'b0}}, inst_q[`INST_Imm]};
    end else if (PC_W == 8) begin : g_imm_eq
      assign jmp_target = inst_q[`INST_Imm];
    end else begin : g_imm_trunc
      assign jmp_target = inst_q[PC_W-1:0];
    end
  endgenerate

  cpu_sequencer_seq_pc #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_seq_pc (
    .clk      (clk),
    .res      (res),
    .jmp      (pc_jmp),
    .jmp_addr (jmp_target),
    .inc      (pc_inc),
    .pc       (pc_w)
  );

  // State register; reset abandons any outstanding fetch
  always_ff @(posedge clk) begin
    if (res) begin
      state <= RETURN_STATE;
    end else begin
      state <= state_nxt;
    end
  end

  // Instruction register loads only on an accepted fetch
  always_ff @(posedge clk) begin
    if (res) begin
      inst_q <= 16'h0000;
    end else if (ir_load) begin
      inst_q <= IMEM_DATA;
    end
  end

  // Retired-instruction counter, wraps modulo 2^CNT_W
  always_ff @(posedge clk) begin
    if (res) begin
      retired_q <= '0;
    end else if (retire) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Next-state logic and phase strobes decoded from the current state
  always_comb begin
    state_nxt = state;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_jmp    = 1'b0;
    retire    = 1'b0;
    IMEM_REQ  = 1'b0;
    DEC_EN    = 1'b0;
    ALU_EN    = 1'b0;
    WB_EN     = 1'b0;
    HALTED    = 1'b0;
    ILLEGAL   = 1'b0;
    case (state)
      SEQ_FETCH: begin
        IMEM_REQ = 1'b1;
        if (IMEM_ACK) begin
          ir_load   = 1'b1;
          pc_inc    = 1'b1;
          state_nxt = SEQ_DECODE;
        end
      end
      SEQ_DECODE: begin
        DEC_EN    = 1'b1;
        state_nxt = SEQ_EXEC;
      end
      SEQ_EXEC: begin
        if (is_alu_op(op)) begin
          ALU_EN    = 1'b1;
          state_nxt = SEQ_WB;
        end else if (op == OP_LOADI) begin
          state_nxt = SEQ_WB;
        end else if (op == OP_HALT) begin
          retire    = 1'b1;
          state_nxt = SEQ_HALT;
        end else begin
          // NOP, JMP and undefined opcodes all retire straight from EXEC
          retire    = 1'b1;
          pc_jmp    = (op == OP_JMP);
          ILLEGAL   = !is_defined_op(op);
          state_nxt = RETURN_STATE;
        end
      end
      SEQ_WB: begin
        WB_EN     = 1'b1;
        retire    = 1'b1;
        state_nxt = RETURN_STATE;
      end
      SEQ_HALT: begin
        HALTED = 1'b1;
      end
`ifdef SEQ_SINGLE_STEP_EN
      SEQ_IDLE: begin
        if (STEP) begin
          state_nxt = SEQ_FETCH;
        end
      end
`endif
      default: begin
        state_nxt = RETURN_STATE;
      end
    endcase
  end

  assign IMEM_ADDR = pc_w;
  assign PC        = pc_w;
  assign INST      = inst_q;
  assign RETIRED   = retired_q;

endmodule
